// File: rtl/sensor_pattern_gen.sv
// Parallel image-sensor test-pattern source: frame/line envelope, divided pixel clock,
// four selectable patterns, completed-frame counter and end-of-frame pulse.
module sensor_pattern_gen #(
  parameter int DATA_W   = 8,
  parameter int H_ACTIVE = 100,
  parameter int H_BLANK  = 4,
  parameter int V_LINES  = 50,
  parameter int V_BLANK  = 8,
  parameter int FV_LEAD  = 2,
  parameter int CLK_DIV  = 1,
  parameter int CHK_LOG2 = 3
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] data_out,
  output logic              clk_out,
  output logic              frame_valid,
  output logic              line_valid,
  output logic              frame_done,
  output logic [15:0]       frame_cnt
);

  localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW   = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam int BMAX = (FV_LEAD > H_BLANK) ? ((FV_LEAD > V_BLANK) ? FV_LEAD : V_BLANK)
                                            : ((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;
  localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(V_LINES - 1);
  localparam logic [BW-1:0] LEAD_LAST = BW'(FV_LEAD - 1);
  localparam logic [BW-1:0] HB_LAST   = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] VB_LAST   = BW'(V_BLANK - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [15:0]   LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {IDLE, LEAD, ACTIVE, HBLANK, VBLANK} state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     div, div_nxt;
  logic [BW-1:0]     cnt, cnt_nxt;
  logic [XW-1:0]     x, x_nxt, x_inc;
  logic [YW-1:0]     y, y_nxt, y_inc;
  logic [15:0]       lfsr, lfsr_nxt, lfsr_adv;
  logic [1:0]        frame_mode, mode_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              clk_nxt, lv_nxt, fv_nxt, done_nxt;
  logic [15:0]       fcnt_nxt;
  logic              div_wrap, boundary;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Coordinates are widened first so the checkerboard bit exists even for narrow x/y.
  function automatic logic [DATA_W-1:0] pixel(input logic [1:0]        m,
                                              input logic [XW-1:0]     px,
                                              input logic [YW-1:0]     py,
                                              input logic [DATA_W-1:0] l);
    logic [31:0] xe, ye, sum;
    xe  = 32'(px);
    ye  = 32'(py);
    sum = xe + ye;
    case (m)
      2'd0:    pixel = sum[DATA_W-1:0];
      2'd1:    pixel = xe[DATA_W-1:0];
      2'd2:    pixel = (xe[CHK_LOG2] ^ ye[CHK_LOG2]) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      default: pixel = l;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    clk_nxt   = clk_out;
    cnt_nxt   = cnt;
    x_nxt     = x;
    y_nxt     = y;
    lfsr_nxt  = lfsr;
    mode_nxt  = frame_mode;
    data_nxt  = data_out;
    lv_nxt    = line_valid;
    fv_nxt    = frame_valid;
    done_nxt  = 1'b0;
    fcnt_nxt  = frame_cnt;
    lfsr_adv  = lfsr_step(lfsr);
    x_inc     = x + XW'(1);
    y_inc     = y + YW'(1);
    div_wrap  = (div == DIV_LAST);
    boundary  = div_wrap && clk_out;

    if (state == IDLE) begin
      div_nxt = '0;
      clk_nxt = 1'b0;
      if (enable) begin
        state_nxt = LEAD;
        cnt_nxt   = '0;
        fv_nxt    = 1'b1;
        lfsr_nxt  = LFSR_SEED;
        mode_nxt  = mode;
        x_nxt     = '0;
        y_nxt     = '0;
      end
    end else begin
      div_nxt = div_wrap ? '0 : div + DW'(1);
      clk_nxt = div_wrap ? ~clk_out : clk_out;
      // Everything visible on the sensor bus moves only on the clk_out falling edge.
      if (boundary) begin
        case (state)
          LEAD: begin
            if (cnt == LEAD_LAST) begin
              state_nxt = ACTIVE;
              x_nxt     = '0;
              y_nxt     = '0;
              lv_nxt    = 1'b1;
              data_nxt  = pixel(frame_mode, '0, '0, lfsr[DATA_W-1:0]);
            end else begin
              cnt_nxt = cnt + BW'(1);
            end
          end
          ACTIVE: begin
            lfsr_nxt = lfsr_adv;
            if (x == X_LAST) begin
              lv_nxt   = 1'b0;
              data_nxt = '0;
              cnt_nxt  = '0;
              if (y == Y_LAST) begin
                state_nxt = VBLANK;
                fv_nxt    = 1'b0;
                done_nxt  = 1'b1;
                fcnt_nxt  = frame_cnt + 16'd1;
              end else begin
                state_nxt = HBLANK;
              end
            end else begin
              x_nxt    = x_inc;
              data_nxt = pixel(frame_mode, x_inc, y, lfsr_adv[DATA_W-1:0]);
            end
          end
          HBLANK: begin
            if (cnt == HB_LAST) begin
              state_nxt = ACTIVE;
              x_nxt     = '0;
              y_nxt     = y_inc;
              lv_nxt    = 1'b1;
              data_nxt  = pixel(frame_mode, '0, y_inc, lfsr[DATA_W-1:0]);
            end else begin
              cnt_nxt = cnt + BW'(1);
            end
          end
          VBLANK: begin
            if (cnt == VB_LAST) begin
              cnt_nxt = '0;
              x_nxt   = '0;
              y_nxt   = '0;
              if (enable) begin
                state_nxt = LEAD;
                fv_nxt    = 1'b1;
                lfsr_nxt  = LFSR_SEED;
                mode_nxt  = mode;
              end else begin
                state_nxt = IDLE;
                div_nxt   = '0;
                clk_nxt   = 1'b0;
              end
            end else begin
              cnt_nxt = cnt + BW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      div         <= '0;
      cnt         <= '0;
      x           <= '0;
      y           <= '0;
      lfsr        <= '0;
      frame_mode  <= '0;
      data_out    <= '0;
      clk_out     <= 1'b0;
      frame_valid <= 1'b0;
      line_valid  <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      div         <= div_nxt;
      cnt         <= cnt_nxt;
      x           <= x_nxt;
      y           <= y_nxt;
      lfsr        <= lfsr_nxt;
      frame_mode  <= mode_nxt;
      data_out    <= data_nxt;
      clk_out     <= clk_nxt;
      frame_valid <= fv_nxt;
      line_valid  <= lv_nxt;
      frame_done  <= done_nxt;
      frame_cnt   <= fcnt_nxt;
    end
  end

endmodule

// File: tb/tb_sensor_pattern_gen.sv
// Bench for sensor_pattern_gen: per-cycle comparison against a frame-timing model derived
// from pixel-period arithmetic, plus a wide-line instance for ramp wrap-around.
module tb_sensor_pattern_gen;
  localparam int DATA_W = 8, H_ACTIVE = 4, H_BLANK = 2, V_LINES = 3, V_BLANK = 3;
  localparam int FV_LEAD = 1, CLK_DIV = 2, CHK_LOG2 = 1;
  localparam int PP       = 2 * CLK_DIV;
  localparam int LP       = H_ACTIVE + H_BLANK;
  localparam int VB_START = FV_LEAD + V_LINES * LP - H_BLANK;
  localparam int FRAME_T  = (VB_START + V_BLANK) * PP;
  localparam int H2       = 300;

  logic              sys_clk = 1'b0;
  logic              sys_rst, enable, enable2;
  logic [1:0]        mode, mode2;
  logic [DATA_W-1:0] data_out, b_data;
  logic              clk_out, frame_valid, line_valid, frame_done;
  logic              b_clk, b_fv, b_lv, b_done;
  logic [15:0]       frame_cnt, b_cnt;

  always #5 sys_clk = ~sys_clk;

  sensor_pattern_gen #(.DATA_W(DATA_W), .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_LINES(V_LINES),
                       .V_BLANK(V_BLANK), .FV_LEAD(FV_LEAD), .CLK_DIV(CLK_DIV), .CHK_LOG2(CHK_LOG2))
  u_dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .mode(mode), .data_out(data_out),
         .clk_out(clk_out), .frame_valid(frame_valid), .line_valid(line_valid),
         .frame_done(frame_done), .frame_cnt(frame_cnt));

  sensor_pattern_gen #(.DATA_W(8), .H_ACTIVE(H2), .H_BLANK(1), .V_LINES(1), .V_BLANK(2),
                       .FV_LEAD(1), .CLK_DIV(1), .CHK_LOG2(3))
  u_dut_wide (.sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable2), .mode(mode2), .data_out(b_data),
              .clk_out(b_clk), .frame_valid(b_fv), .line_valid(b_lv),
              .frame_done(b_done), .frame_cnt(b_cnt));

  int n_checks = 0, n_fail = 0;
  bit m_busy = 0;
  int m_t = 0, m_mode = 0, m_cnt = 0;
  int e_fv, e_lv, e_clk, e_data, e_done, e_y;
  logic [15:0] lfsr_seq [0:H_ACTIVE*V_LINES-1];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pat(input int m, input int x, input int y);
    int v;
    case (m)
      0: v = x + y;
      1: v = x;
      2: v = (((x >> CHK_LOG2) ^ (y >> CHK_LOG2)) & 1) != 0 ? (1 << DATA_W) - 1 : 0;
      default: v = int'(lfsr_seq[y * H_ACTIVE + x]);
    endcase
    return v & ((1 << DATA_W) - 1);
  endfunction

  // Advance the model by one sys_clk edge, then compare all outputs just after the edge.
  task automatic step();
    int p, q, xx;
    @(posedge sys_clk);
    if (sys_rst) begin
      m_busy = 0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (enable) begin m_busy = 1; m_t = 0; m_mode = int'(mode); end
    end else begin
      m_t++;
      if (m_t == FRAME_T) begin
        if (enable) begin m_t = 0; m_mode = int'(mode); end
        else m_busy = 0;
      end
    end
    if (m_busy && m_t == VB_START * PP) m_cnt = (m_cnt + 1) & 16'hFFFF;

    e_fv = 0; e_lv = 0; e_clk = 0; e_data = 0; e_done = 0; e_y = -1;
    if (m_busy) begin
      p      = m_t / PP;
      e_clk  = ((m_t % PP) >= CLK_DIV) ? 1 : 0;
      e_done = (m_t == VB_START * PP) ? 1 : 0;
      if (p < FV_LEAD) e_fv = 1;
      else if (p < VB_START) begin
        e_fv = 1;
        q    = p - FV_LEAD;
        e_y  = q / LP;
        xx   = q % LP;
        if (xx < H_ACTIVE) begin e_lv = 1; e_data = pat(m_mode, xx, e_y); end
      end
    end
    #1;
    chk("frame_valid", int'(frame_valid), e_fv);
    chk("line_valid", int'(line_valid), e_lv);
    chk("clk_out", int'(clk_out), e_clk);
    chk("data_out", int'(data_out), e_data);
    chk("frame_done", int'(frame_done), e_done);
    chk("frame_cnt", int'(frame_cnt), m_cnt);
  endtask

  // Mode is scrambled mid-frame; only the target value is presented at frame starts.
  task automatic run(input int cycles, input int target, input bit toggle_en);
    for (int i = 0; i < cycles; i++) begin
      step();
      if (m_busy && m_t >= 8 && m_t < FRAME_T - 8) mode = 2'($urandom_range(0, 3));
      else mode = 2'(target);
      if (toggle_en && $urandom_range(0, 39) == 0) enable = ~enable;
    end
  endtask

  initial begin
    int cnt0, n, found;
    bit seen, done;
    lfsr_seq[0] = 16'hACE1;
    for (int i = 1; i < H_ACTIVE * V_LINES; i++)
      lfsr_seq[i] = {lfsr_seq[i-1][14:0],
                     lfsr_seq[i-1][15] ^ lfsr_seq[i-1][13] ^ lfsr_seq[i-1][12] ^ lfsr_seq[i-1][10]};

    sys_rst = 1'b1; enable = 1'b0; mode = 2'd0; enable2 = 1'b0; mode2 = 2'd0;
    step();
    step();
    sys_rst = 1'b0;
    run(3, 0, 0);

    // Continuous frames in each mode, with mid-frame mode noise.
    enable = 1'b1;
    for (int m = 0; m < 4; m++) run(2 * FRAME_T + 7, m, 0);

    // Enable dropped during line 1: the frame must complete, then idle.
    found = 0;
    for (int i = 0; i < 4 * FRAME_T && found == 0; i++) begin
      run(1, 0, 0);
      if (e_lv == 1 && e_y == 1) found = 1;
    end
    chk("wait_line1", found, 1);
    enable = 1'b0;
    cnt0 = m_cnt;
    run(FRAME_T + 40, 0, 0);
    chk("drop_cnt", int'(frame_cnt), (cnt0 + 1) & 16'hFFFF);
    chk("drop_idle_fv", int'(frame_valid), 0);

    // Random enable toggling.
    enable = 1'b1;
    run(600, 3, 1);

    // Asynchronous reset while a line is active.
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 4 * FRAME_T && found == 0; i++) begin
      run(1, 0, 0);
      if (e_lv == 1) found = 1;
    end
    chk("wait_active", found, 1);
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_data", int'(data_out), 0);
    chk("rst_lv", int'(line_valid), 0);
    chk("rst_fv", int'(frame_valid), 0);
    chk("rst_clk", int'(clk_out), 0);
    chk("rst_cnt", int'(frame_cnt), 0);
    run(2, 0, 0);
    sys_rst = 1'b0;
    run(FRAME_T + 20, 0, 0);
    enable = 1'b0;
    run(FRAME_T + 10, 0, 0);

    // Wide-line ramp: value must wrap 255 -> 0 at x = 256.
    enable2 = 1'b1; mode2 = 2'd1;
    n = 0; seen = 0; done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge sys_clk);
      #1;
      if (b_lv && b_clk) begin
        chk("wide_ramp", int'(b_data), n % 256);
        if (n == 256) chk("wrap_256", int'(b_data), 0);
        n++;
        seen = 1;
      end else if (seen && !b_lv) done = 1;
    end
    chk("wide_len", n, H2);
    enable2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
